// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with operand forwarding muxes, load-use hazard detection and a stall counter.
// Latency 1 cycle; stall is combinational from E-stage state, and a hazard or flush loads a bubble.
module id_exe_stage #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             dwreg,
   input  logic             dm2reg,
   input  logic             dwmem,
   input  logic             daluimm,
   input  logic             dshift,
   input  logic             djal,
   input  logic [3:0]       daluc,
   input  logic [4:0]       drn,
   input  logic [4:0]       drs,
   input  logic [4:0]       drt,
   input  logic             use_rs,
   input  logic             use_rt,
   input  logic [31:0]      da,
   input  logic [31:0]      db,
   input  logic [31:0]      dimm,
   input  logic [31:0]      dpc4,
   input  logic [1:0]       fwda,
   input  logic [1:0]       fwdb,
   input  logic [31:0]      ealu,
   input  logic [31:0]      malu,
   input  logic [31:0]      mmo,
   input  logic             flush,
   output logic             stall,
   output logic             ewreg,
   output logic             em2reg,
   output logic             ewmem,
   output logic             ealuimm,
   output logic             eshift,
   output logic             ejal,
   output logic [3:0]       ealuc,
   output logic [4:0]       ern,
   output logic [31:0]      ea,
   output logic [31:0]      eb,
   output logic [31:0]      eimm,
   output logic [31:0]      epc4,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic        wreg;
      logic        m2reg;
      logic        wmem;
      logic        aluimm;
      logic        shift;
      logic        jal;
      logic [3:0]  aluc;
      logic [4:0]  rn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [31:0] pc4;
   } ex_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   ex_t             ex_q, ex_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [31:0]     fa, fb;
   logic            hit_rs, hit_rt, bubble;

   function automatic logic [31:0] fwd_sel(input logic [1:0]  sel,
                                           input logic [31:0] rf,
                                           input logic [31:0] e_alu,
                                           input logic [31:0] m_alu,
                                           input logic [31:0] m_mo);
      logic [31:0] r;
      case (sel)
         2'b00:   r = rf;
         2'b01:   r = e_alu;
         2'b10:   r = m_alu;
         default: r = m_mo;
      endcase
      return r;
   endfunction

   // A load in E whose result is needed by ID cannot be forwarded yet; r0 is never a real dependency.
   always_comb begin
      hit_rs = use_rs && (ex_q.rn == drs);
      hit_rt = use_rt && (ex_q.rn == drt);
      stall  = ex_q.wreg && ex_q.m2reg && (ex_q.rn != 5'd0) && (hit_rs || hit_rt);
      bubble = stall || flush;
   end

   always_comb begin
      fa = fwd_sel(fwda, da, ealu, malu, mmo);
      fb = fwd_sel(fwdb, db, ealu, malu, mmo);
   end

   always_comb begin
      ex_d = '0;
      if (!bubble) begin
         ex_d.wreg   = dwreg;
         ex_d.m2reg  = dm2reg;
         ex_d.wmem   = dwmem;
         ex_d.aluimm = daluimm;
         ex_d.shift  = dshift;
         ex_d.jal    = djal;
         ex_d.aluc   = daluc;
         ex_d.rn     = drn;
         ex_d.a      = fa;
         ex_d.b      = fb;
         ex_d.imm    = dimm;
         ex_d.pc4    = dpc4;
      end
   end

   // Saturating count of load-use stall cycles; flushes are not counted.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ex_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign ewreg     = ex_q.wreg;
   assign em2reg    = ex_q.m2reg;
   assign ewmem     = ex_q.wmem;
   assign ealuimm   = ex_q.aluimm;
   assign eshift    = ex_q.shift;
   assign ejal      = ex_q.jal;
   assign ealuc     = ex_q.aluc;
   assign ern       = ex_q.rn;
   assign ea        = ex_q.a;
   assign eb        = ex_q.b;
   assign eimm      = ex_q.imm;
   assign epc4      = ex_q.pc4;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_exe_stage.sv
// Randomized and directed bench for id_exe_stage against a transaction-level model of the E stage.
// A second instance with a 2-bit counter exercises saturation.
module tb_id_exe_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        dwreg, dm2reg, dwmem, daluimm, dshift, djal;
   logic [3:0]  daluc;
   logic [4:0]  drn, drs, drt;
   logic        use_rs, use_rt;
   logic [31:0] da, db, dimm, dpc4;
   logic [1:0]  fwda, fwdb;
   logic [31:0] ealu, malu, mmo;
   logic        flush;

   logic        stall, ewreg, em2reg, ewmem, ealuimm, eshift, ejal;
   logic [3:0]  ealuc;
   logic [4:0]  ern;
   logic [31:0] ea, eb, eimm, epc4;
   logic [15:0] stall_cnt;

   logic        stall_s, ewreg_s, em2reg_s, ewmem_s, ealuimm_s, eshift_s, ejal_s;
   logic [3:0]  ealuc_s;
   logic [4:0]  ern_s;
   logic [31:0] ea_s, eb_s, eimm_s, epc4_s;
   logic [1:0]  stall_cnt_s;

   always #5 clock = ~clock;

   id_exe_stage #(.CNT_W(16)) dut (
      .clock(clock), .reset(reset),
      .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluimm(daluimm), .dshift(dshift), .djal(djal),
      .daluc(daluc), .drn(drn), .drs(drs), .drt(drt), .use_rs(use_rs), .use_rt(use_rt),
      .da(da), .db(db), .dimm(dimm), .dpc4(dpc4), .fwda(fwda), .fwdb(fwdb),
      .ealu(ealu), .malu(malu), .mmo(mmo), .flush(flush), .stall(stall),
      .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ealuimm(ealuimm), .eshift(eshift), .ejal(ejal),
      .ealuc(ealuc), .ern(ern), .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4), .stall_cnt(stall_cnt)
   );

   id_exe_stage #(.CNT_W(2)) dut_sat (
      .clock(clock), .reset(reset),
      .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluimm(daluimm), .dshift(dshift), .djal(djal),
      .daluc(daluc), .drn(drn), .drs(drs), .drt(drt), .use_rs(use_rs), .use_rt(use_rt),
      .da(da), .db(db), .dimm(dimm), .dpc4(dpc4), .fwda(fwda), .fwdb(fwdb),
      .ealu(ealu), .malu(malu), .mmo(mmo), .flush(flush), .stall(stall_s),
      .ewreg(ewreg_s), .em2reg(em2reg_s), .ewmem(ewmem_s), .ealuimm(ealuimm_s), .eshift(eshift_s),
      .ejal(ejal_s), .ealuc(ealuc_s), .ern(ern_s), .ea(ea_s), .eb(eb_s), .eimm(eimm_s), .epc4(epc4_s),
      .stall_cnt(stall_cnt_s)
   );

   // Reference model: the instruction currently held in E, plus stall totals.
   typedef struct {
      bit        wreg, m2reg, wmem, aluimm, shift, jal;
      bit [3:0]  aluc;
      bit [4:0]  rn;
      bit [31:0] a, b, imm, pc4;
   } einst_t;

   einst_t m;
   int     m_cnt16, m_cnt2;
   int     checks = 0;
   int     errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_stall();
      bit needs_load;
      needs_load = (use_rs && drs == m.rn) || (use_rt && drt == m.rn);
      return m.wreg && m.m2reg && (m.rn != 0) && needs_load;
   endfunction

   task automatic model_clear();
      m = '{default: 0};
      m_cnt16 = 0;
      m_cnt2 = 0;
   endtask

   task automatic model_edge(input bit s);
      logic [31:0] src_a [4];
      logic [31:0] src_b [4];
      src_a = '{da, ealu, malu, mmo};
      src_b = '{db, ealu, malu, mmo};
      if (s) begin
         if (m_cnt16 < 65535) m_cnt16++;
         if (m_cnt2 < 3) m_cnt2++;
      end
      if (s || flush) begin
         m = '{default: 0};
      end else begin
         m.wreg = dwreg; m.m2reg = dm2reg; m.wmem = dwmem;
         m.aluimm = daluimm; m.shift = dshift; m.jal = djal;
         m.aluc = daluc; m.rn = drn;
         m.a = src_a[fwda]; m.b = src_b[fwdb];
         m.imm = dimm; m.pc4 = dpc4;
      end
   endtask

   task automatic check_outputs();
      chk("ctl", {ewreg, em2reg, ewmem, ealuimm, eshift, ejal, ealuc, ern},
          {m.wreg, m.m2reg, m.wmem, m.aluimm, m.shift, m.jal, m.aluc, m.rn});
      chk("ea", ea, m.a);
      chk("eb", eb, m.b);
      chk("eimm", eimm, m.imm);
      chk("epc4", epc4, m.pc4);
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt16));
      chk("stall_cnt_sat", 32'(stall_cnt_s), 32'(m_cnt2));
   endtask

   // Called just after a falling edge with ID inputs already applied.
   task automatic cycle();
      bit s;
      #1;
      s = model_stall();
      chk("stall", stall, s);
      @(posedge clock);
      model_edge(s);
      #1;
      check_outputs();
      @(negedge clock);
   endtask

   task automatic idle();
      {dwreg, dm2reg, dwmem, daluimm, dshift, djal} = '0;
      daluc = '0; drn = '0; drs = '0; drt = '0;
      use_rs = 0; use_rt = 0; flush = 0;
      da = '0; db = '0; dimm = '0; dpc4 = '0;
      fwda = '0; fwdb = '0; ealu = '0; malu = '0; mmo = '0;
   endtask

   task automatic load_lw(input logic [4:0] rn);
      idle();
      dwreg = 1; dm2reg = 1; drn = rn;
      cycle();
   endtask

   initial begin
      idle();
      reset = 1;
      model_clear();
      #1;
      chk("reset_stall", stall, 0);
      check_outputs();
      repeat (2) @(negedge clock);
      reset = 0;

      // Plain ALU instruction advances
      idle();
      dwreg = 1; drn = 5; da = 32'h11; db = 32'h22; dimm = 32'h7; dpc4 = 32'h104;
      cycle();
      chk("add_ewreg", ewreg, 1);
      chk("add_ern", ern, 5);
      chk("add_ea", ea, 32'h11);
      chk("add_eb", eb, 32'h22);

      // Load-use on rs: one bubble, then forwarded load data
      load_lw(5'd8);
      idle(); drs = 8; use_rs = 1;
      #1 chk("lu_stall", stall, 1);
      cycle();
      chk("lu_bubble", {ewreg, ern}, 0);
      chk("lu_cnt", stall_cnt, 1);
      fwda = 2'b11; mmo = 32'hCAFE; dwreg = 1; drn = 9;
      cycle();
      chk("lu_fwd", ea, 32'hCAFE);

      // rt matches but is not read
      load_lw(5'd8);
      idle(); drt = 8; use_rt = 0; dwreg = 1; drn = 3;
      #1 chk("nouse_stall", stall, 0);
      cycle();
      chk("nouse_ern", ern, 3);

      // Load to r0 never stalls
      load_lw(5'd0);
      idle(); drs = 0; use_rs = 1;
      #1 chk("r0_stall", stall, 0);
      cycle();

      // Forward select sweep
      for (int i = 0; i < 4; i++) begin
         idle(); da = 1; db = 1; ealu = 2; malu = 3; mmo = 4; fwda = 2'(i);
         cycle();
         chk("sweep_ea", ea, 32'(i + 1));
      end
      for (int i = 0; i < 4; i++) begin
         idle(); da = 1; db = 1; ealu = 2; malu = 3; mmo = 4; fwdb = 2'(i);
         cycle();
         chk("sweep_eb", eb, 32'(i + 1));
      end

      // Stall and flush together
      load_lw(5'd12);
      idle(); drt = 12; use_rt = 1; flush = 1; dwreg = 1; drn = 4;
      cycle();
      chk("sf_bubble", {ewreg, ewmem, ern}, 0);
      chk("sf_cnt", stall_cnt, 2);

      // Flush alone is a bubble but not counted
      idle(); dwreg = 1; dwmem = 1; drn = 6; flush = 1;
      cycle();
      chk("fl_cnt", stall_cnt, 2);

      // Five more stalls saturate the 2-bit counter
      for (int i = 0; i < 5; i++) begin
         load_lw(5'd20);
         idle(); drs = 20; use_rs = 1;
         cycle();
      end
      chk("sat_cnt2", stall_cnt_s, 3);
      chk("sat_cnt16", stall_cnt, 7);

      // Reset while a stall is pending
      load_lw(5'd7);
      idle(); drs = 7; use_rs = 1;
      #1 chk("rst_pre_stall", stall, 1);
      #1 reset = 1;
      model_clear();
      #1;
      chk("rst_mid_stall", stall, 0);
      check_outputs();
      @(negedge clock);
      reset = 0;

      // Random traffic with small register numbers to provoke hazards
      for (int n = 0; n < 400; n++) begin
         dwreg = 1'($urandom); dm2reg = 1'($urandom); dwmem = 1'($urandom);
         daluimm = 1'($urandom); dshift = 1'($urandom); djal = 1'($urandom);
         daluc = 4'($urandom); drn = 5'($urandom_range(0, 3));
         drs = 5'($urandom_range(0, 3)); drt = 5'($urandom_range(0, 3));
         use_rs = 1'($urandom); use_rt = 1'($urandom);
         da = $urandom; db = $urandom; dimm = $urandom; dpc4 = $urandom;
         fwda = 2'($urandom); fwdb = 2'($urandom);
         ealu = $urandom; malu = $urandom; mmo = $urandom;
         flush = ($urandom_range(0, 7) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
